mem_responder: RTL and testbench



---
 rtl/mem_responder.sv | 165 ++++++++++++++++
 tb/tb_mem_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for a strobe-based memory interface.
// Holds a 2^ADDR_WIDTH x DATA_WIDTH array. Each 0->1 transition of
// mem_clock seen in IDLE starts one transaction. The responder waits
// WAIT_STATES cycles, performs one read or write, then raises mem_ready
// and holds it until mem_clock is sampled low.
//
// Optional feature (macro MEM_RESP_WRITE_PROTECT_EN): writes whose latched
// address is >= PROTECT_BASE are discarded, from_mem returns the stored
// word, and mem_err is raised together with mem_ready.
//
// Ports:
//   clock      in   system clock, rising-edge active
//   reset_n    in   asynchronous active-low reset
//   address    in   transaction address          [ADDR_WIDTH]
//   to_mem     in   write data                   [DATA_WIDTH]
//   mem_clock  in   request strobe (rising edge starts a transaction)
//   mem_write  in   1 = write, 0 = read
//   from_mem   out  read data or write echo      [DATA_WIDTH]
//   mem_ready  out  transaction complete
//   mem_err    out  protected-write flag (0 unless the feature is enabled)
module mem_responder #(
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    WAIT_STATES  = 0,
    parameter logic [ADDR_WIDTH-1:0] PROTECT_BASE = 8'hF0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] to_mem,
    input  logic                  mem_clock,
    input  logic                  mem_write,
    output logic [DATA_WIDTH-1:0] from_mem,
    output logic                  mem_ready,
    output logic                  mem_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t                state_q,     state_d;
    logic [3:0]            cnt_q,       cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] data_q,      data_d;
    logic                  write_q,     write_d;
    logic [DATA_WIDTH-1:0] from_mem_q,  from_mem_d;
    logic                  ready_q,     ready_d;
    logic                  err_q,       err_d;
    logic                  mem_clock_q;

    logic                  req;
    logic                  mem_we;
    logic                  prot_hit;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef MEM_RESP_WRITE_PROTECT_EN
    assign prot_hit = write_q && (addr_q >= PROTECT_BASE);
`else
    logic unused_protect;
    assign unused_protect = ^PROTECT_BASE;
    assign prot_hit       = 1'b0;
`endif

    // A request is the first cycle mem_clock is seen high after being low.
    assign req = mem_clock & ~mem_clock_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        write_d    = write_q;
        from_mem_d = from_mem_q;
        ready_d    = ready_q;
        err_d      = err_q;
        mem_we     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = address;
                    data_d  = to_mem;
                    write_d = mem_write;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (write_q && !prot_hit) begin
                    mem_we     = 1'b1;
                    from_mem_d = data_q;
                end else begin
                    // Reads, and discarded protected writes, return the stored word.
                    from_mem_d = mem[addr_q];
                end
                err_d   = prot_hit;
                ready_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!mem_clock) begin
                    ready_d = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            write_q     <= 1'b0;
            from_mem_q  <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            mem_clock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            write_q     <= write_d;
            from_mem_q  <= from_mem_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            mem_clock_q <= mem_clock;
        end
    end

    // NOTE: the storage array has no reset so it maps onto plain RAM;
    // its contents survive reset_n. A write in flight is lost on reset
    // because mem_we is only high in ACCESS, which reset leaves.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[addr_q] <= data_q;
        end
    end

    assign from_mem  = from_mem_q;
    assign mem_ready = ready_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder. Two instances share the clock and
// reset: index 0 has WAIT_STATES=0, index 1 has WAIT_STATES=3. A reference
// array per instance predicts read data, echoes and the protect flag.
module tb_mem_responder;

    logic       clk;
    logic       reset_n;
    logic [7:0] addr  [2];
    logic [7:0] wdat  [2];
    logic [7:0] rdata [2];
    logic       strb  [2];
    logic       wen   [2];
    logic       rdy   [2];
    logic       err   [2];

    int errors = 0;
    int checks = 0;

    logic [7:0] ref_mem [2][256];
    int         rises   [2];
    logic       rdy_prev[2];

    mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(0), .PROTECT_BASE(8'hF0)) u_dut0 (
        .clock(clk), .reset_n(reset_n), .address(addr[0]), .to_mem(wdat[0]),
        .mem_clock(strb[0]), .mem_write(wen[0]), .from_mem(rdata[0]),
        .mem_ready(rdy[0]), .mem_err(err[0])
    );

    mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(3), .PROTECT_BASE(8'hF0)) u_dut3 (
        .clock(clk), .reset_n(reset_n), .address(addr[1]), .to_mem(wdat[1]),
        .mem_clock(strb[1]), .mem_write(wen[1]), .from_mem(rdata[1]),
        .mem_ready(rdy[1]), .mem_err(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts rising edges of mem_ready per instance.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rdy[d] && !rdy_prev[d]) rises[d] <= rises[d] + 1;
            rdy_prev[d] <= rdy[d];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Reference: protected writes are dropped; writes echo their data;
    // everything else returns the stored word.
    task automatic model_txn(input int d, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                             output logic [7:0] ed, output logic ee);
        logic prot;
        prot = 1'b0;
`ifdef MEM_RESP_WRITE_PROTECT_EN
        prot = wr && (a >= 8'hF0);
`endif
        if (wr && !prot) ref_mem[d][a] = wd;
        ed = ref_mem[d][a];
        ee = prot;
    endtask

    // mode 0: strobe held through DONE; mode 1: strobe dropped right after
    // capture; mode 2: strobe dropped then re-raised during the wait.
    task automatic txn(input int d, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                       input int mode, input string tag);
        logic [7:0] ed;
        logic       ee;
        int         lat;
        int         r0;
        model_txn(d, wr, a, wd, ed, ee);
        @(negedge clk);
        r0      = rises[d];
        addr[d] = a;
        wdat[d] = wd;
        wen[d]  = wr;
        strb[d] = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                addr[d] = ~a;
                wdat[d] = ~wd;
                wen[d]  = ~wr;
                if (mode != 0) strb[d] = 1'b0;
            end
            if (k == 2 && mode == 2) strb[d] = 1'b1;
            @(posedge clk);
            #1;
            if (rdy[d]) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, lat, ws(d) + 1);
        check({tag, " data"}, rdata[d], ed);
        check({tag, " err"}, err[d], ee);
        if (strb[d]) begin
            @(posedge clk);
            #1;
            check({tag, " ready held"}, rdy[d], 1'b1);
            @(negedge clk);
            strb[d] = 1'b0;
        end
        @(posedge clk);
        #1;
        check({tag, " ready clear"}, rdy[d], 1'b0);
        check({tag, " err clear"}, err[d], 1'b0);
        check({tag, " data hold"}, rdata[d], ed);
        check({tag, " ready pulses"}, rises[d] - r0, 1);
    endtask

    initial begin
        logic [7:0] a;
        int         d;
        int         mode;
        int         sel;

        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 256; j++) ref_mem[i][j] = 8'h00;
            addr[i] = 8'h00; wdat[i] = 8'h00; strb[i] = 1'b0; wen[i] = 1'b0;
            rises[i] = 0; rdy_prev[i] = 1'b0;
        end

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset ready", rdy[i], 1'b0);
            check("reset data", rdata[i], 8'h00);
            check("reset err", err[i], 1'b0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        txn(0, 1'b0, 8'h00, 8'h00, 0, "ws0 read 00");
        txn(0, 1'b1, 8'h12, 8'h5A, 0, "ws0 write 12");
        txn(0, 1'b0, 8'h12, 8'h00, 0, "ws0 read 12");
        txn(0, 1'b0, 8'h13, 8'h00, 0, "ws0 read 13");
        txn(0, 1'b1, 8'hFF, 8'h81, 0, "ws0 write ff");
        txn(0, 1'b0, 8'hFF, 8'h00, 1, "ws0 read ff drop");

        txn(1, 1'b1, 8'h40, 8'hC3, 0, "ws3 write 40");
        txn(1, 1'b0, 8'h40, 8'h00, 0, "ws3 read 40");
        txn(1, 1'b0, 8'h40, 8'h00, 2, "ws3 repulse");
        txn(1, 1'b1, 8'h41, 8'h33, 1, "ws3 drop write");
        txn(1, 1'b0, 8'h41, 8'h00, 1, "ws3 drop read");

        // Reset during the wait of a write: nothing committed, outputs zeroed.
        @(negedge clk);
        addr[1] = 8'h20; wdat[1] = 8'hAA; wen[1] = 1'b1; strb[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        strb[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset ready", rdy[1], 1'b0);
        check("midreset data", rdata[1], 8'h00);
        check("midreset err", err[1], 1'b0);
        check("midreset ws0 data", rdata[0], 8'h00);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        txn(1, 1'b0, 8'h20, 8'h00, 0, "ws3 read 20 after reset");
        txn(1, 1'b0, 8'h40, 8'h00, 0, "ws3 read 40 after reset");

        txn(0, 1'b1, 8'hF5, 8'h77, 0, "protect write f5");
        txn(0, 1'b0, 8'hF5, 8'h00, 0, "protect read f5");
        txn(0, 1'b1, 8'hEF, 8'h66, 0, "protect write ef");
        txn(0, 1'b0, 8'hEF, 8'h00, 0, "protect read ef");
        txn(1, 1'b1, 8'hF0, 8'h19, 1, "protect write f0");

        for (int n = 0; n < 40; n++) begin
            d   = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 3));
            case (sel)
                0, 1:    a = 8'($urandom_range(0, 15));
                2:       a = 8'($urandom_range(8'hEE, 8'hF1));
                default: a = 8'hFF;
            endcase
            mode = int'($urandom_range(0, 2));
            if (d == 0 && mode == 2) mode = 0;
            txn(d, 1'($urandom_range(0, 1)), a, 8'($urandom), mode, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
